// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory handshake
// and the pre-decoded issue-side head port.
interface instr_fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_valid;
    logic [31:0] imem_data;

    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_pc;
    logic [31:0] instr_word;
    logic [6:0]  operatorType;
    logic [2:0]  operatorSubType;
    logic        operatorFlag;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_valid,
        input  imem_data,
        output instr_valid,
        input  instr_ready,
        output instr_pc,
        output instr_word,
        output operatorType,
        output operatorSubType,
        output operatorFlag,
        output rd,
        output rs1,
        output rs2
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_valid,
        output imem_data,
        input  instr_valid,
        output instr_ready,
        input  instr_pc,
        input  instr_word,
        input  operatorType,
        input  operatorSubType,
        input  operatorFlag,
        input  rd,
        input  rs1,
        input  rs2
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch + pre-decode queue: one outstanding
// memory read at a time, buffered in a small circular FIFO.
module instr_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic [31:0]          pc,
    input  logic                 fetch_en,
    input  logic                 flush,
    output logic                 busy,
    output logic [PTR_W:0]       count,
    instr_fetch_queue_if.master  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    localparam logic [PTR_W:0] FULL  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] CNT1  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR1 = PTR_W'(1);

    logic [1:0]       state;
    logic [1:0]       state_n;
    logic [31:0]      addr_r;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] word_mem [DEPTH];

    logic        start;
    logic        wr_en;
    logic        rd_en;
    logic        head_ok;
    logic [31:0] hd_pc;
    logic [31:0] hd_word;

    assign head_ok = (count != '0);
    assign busy    = (state != S_IDLE) | (count == FULL) | flush;
    assign start   = (state == S_IDLE) & fetch_en & ~busy;

    // Flush wins over both queue ports in the same edge.
    assign wr_en = (state == S_WAIT) & bus.imem_valid & ~flush;
    assign rd_en = head_ok & bus.instr_ready & ~flush;

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: if (start) state_n = S_REQ;
            S_REQ: begin
                if (flush)               state_n = S_IDLE;
                else if (bus.imem_ready) state_n = S_WAIT;
            end
            S_WAIT: begin
                if (bus.imem_valid) state_n = S_IDLE;
                else if (flush)     state_n = S_DROP;
            end
            S_DROP: if (bus.imem_valid) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            addr_r <= '0;
        end else begin
            state <= state_n;
            if (start) addr_r <= pc;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR1;
            if (rd_en) rd_ptr <= rd_ptr + PTR1;
            if (wr_en && !rd_en)      count <= count + CNT1;
            else if (rd_en && !wr_en) count <= count - CNT1;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            pc_mem[wr_ptr]   <= addr_r;
            word_mem[wr_ptr] <= bus.imem_data;
        end
    end

    // Storage is not reset, so head fields are masked when empty.
    assign hd_pc   = pc_mem[rd_ptr]   & {32{head_ok}};
    assign hd_word = word_mem[rd_ptr] & {32{head_ok}};

    assign bus.imem_req  = (state == S_REQ);
    assign bus.imem_addr = addr_r;

    assign bus.instr_valid     = head_ok;
    assign bus.instr_pc        = hd_pc;
    assign bus.instr_word      = hd_word;
    assign bus.operatorType    = hd_word[6:0];
    assign bus.operatorSubType = hd_word[14:12];
    assign bus.operatorFlag    = hd_word[30];
    assign bus.rd              = hd_word[11:7];
    assign bus.rs1             = hd_word[19:15];
    assign bus.rs2             = hd_word[24:20];

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios then random
// traffic, checked each cycle against a transaction-level model.
module tb_instr_fetch_queue;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clock = 1'b0;
    logic             rst_n = 1'b0;
    logic [31:0]      pc = '0;
    logic             fetch_en = 1'b0;
    logic             flush = 1'b0;
    logic             busy;
    logic [PTR_W:0]   count;

    instr_fetch_queue_if bus ();

    instr_fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .pc       (pc),
        .fetch_en (fetch_en),
        .flush    (flush),
        .busy     (busy),
        .count    (count),
        .bus      (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] w;
    } ent_t;

    int errors = 0;
    int checks = 0;

    // Model: queued entries plus the one outstanding transaction.
    // phase 0 = none, 1 = requested, 2 = accepted; live=0 means discard.
    ent_t        q[$];
    int          phase = 0;
    bit          live = 1'b0;
    logic [31:0] maddr = '0;

    bit directed = 1'b1;
    int lat = 0;
    int prev_phase = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        phase = 0;
        live  = 1'b0;
        maddr = '0;
    endtask

    task automatic model_step();
        bit bm;
        if (!rst_n) return;
        bm = (phase != 0) || (q.size() == DEPTH) || flush;
        if (flush) begin
            q.delete();
        end else begin
            if (q.size() != 0 && bus.instr_ready) void'(q.pop_front());
            if (phase == 2 && bus.imem_valid && live)
                q.push_back(ent_t'{maddr, bus.imem_data});
        end
        case (phase)
            0: if (fetch_en && !bm) begin
                phase = 1;
                live  = 1'b1;
                maddr = pc;
            end
            1: if (flush) phase = 0;
               else if (bus.imem_ready) phase = 2;
            default: if (bus.imem_valid) phase = 0;
                     else if (flush) live = 1'b0;
        endcase
    endtask

    always @(negedge clock) begin : compare
        ent_t        h;
        logic [31:0] w;
        h = ent_t'{32'h0, 32'h0};
        if (q.size() != 0) h = q[0];
        w = h.w;
        chk("count", 32'(count), q.size());
        chk("instr_valid", 32'(bus.instr_valid), 32'(q.size() != 0));
        chk("instr_pc", bus.instr_pc, h.a);
        chk("instr_word", bus.instr_word, w);
        chk("operatorType", 32'(bus.operatorType), 32'(w[6:0]));
        chk("operatorSubType", 32'(bus.operatorSubType), 32'(w[14:12]));
        chk("operatorFlag", 32'(bus.operatorFlag), 32'(w[30]));
        chk("rd", 32'(bus.rd), 32'(w[11:7]));
        chk("rs1", 32'(bus.rs1), 32'(w[19:15]));
        chk("rs2", 32'(bus.rs2), 32'(w[24:20]));
        chk("imem_req", 32'(bus.imem_req), 32'(phase == 1));
        if (phase == 1) chk("imem_addr", bus.imem_addr, maddr);
        chk("busy", 32'(busy),
            32'((phase != 0) || (q.size() == DEPTH) || flush));
    end

    task automatic rand_drive();
        if (rst_n && $urandom_range(0, 499) == 0) begin
            rst_n = 1'b0;
            model_reset();
        end else begin
            rst_n = 1'b1;
        end
        fetch_en         = ($urandom_range(0, 2) != 0);
        pc               = $urandom_range(0, 63);
        flush            = ($urandom_range(0, 19) == 0);
        bus.instr_ready  = ($urandom_range(0, 2) != 0);
        bus.imem_ready   = ($urandom_range(0, 2) == 0);
        bus.imem_data    = $urandom;
        bus.imem_valid   = 1'b0;
        if (phase == 2) begin
            if (prev_phase != 2) lat = $urandom_range(0, 4);
            if (lat == 0) bus.imem_valid = 1'b1;
            else lat--;
        end else if (phase == 0) begin
            bus.imem_valid = ($urandom_range(0, 9) == 0);
        end
        prev_phase = phase;
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        #2;
        if (!directed) rand_drive();
    endtask

    task automatic fetch(input logic [31:0] p, input logic [31:0] d);
        pc = p;
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        bus.imem_ready = 1'b1;
        step();
        bus.imem_ready = 1'b0;
        bus.imem_valid = 1'b1;
        bus.imem_data  = d;
        step();
        bus.imem_valid = 1'b0;
    endtask

    initial begin
        bus.imem_ready  = 1'b0;
        bus.imem_valid  = 1'b0;
        bus.imem_data   = '0;
        bus.instr_ready = 1'b0;
        model_reset();
        repeat (2) step();
        rst_n = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(bus.instr_valid), 0);
        chk("rst_req", 32'(bus.imem_req), 0);
        chk("rst_addr", bus.imem_addr, 0);

        // Single fetch, 1-cycle memory, issue always ready.
        bus.instr_ready = 1'b1;
        fetch(32'd0, 32'h00A50533);
        #1;
        chk("t1_valid", 32'(bus.instr_valid), 1);
        chk("t1_optype", 32'(bus.operatorType), 32'h33);
        chk("t1_rd", 32'(bus.rd), 10);
        chk("t1_rs1", 32'(bus.rs1), 10);
        chk("t1_rs2", 32'(bus.rs2), 10);
        chk("t1_flag", 32'(bus.operatorFlag), 0);
        chk("t1_pc", bus.instr_pc, 0);
        step();
        #1;
        chk("t1_drain", 32'(count), 0);

        // Fill, stall on full, then pop and wrap.
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) fetch(32'(i), 32'h1000_0013 + 32'(i << 7));
        #1;
        chk("t2_count", 32'(count), 4);
        chk("t2_busy", 32'(busy), 1);
        pc = 32'd4;
        fetch_en = 1'b1;
        step();
        step();
        #1;
        chk("t2_noreq", 32'(bus.imem_req), 0);
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        step();
        fetch_en = 1'b0;
        #1;
        chk("t2_req", 32'(bus.imem_req), 1);
        chk("t2_addr", bus.imem_addr, 4);
        bus.imem_ready = 1'b1;
        step();
        bus.imem_ready = 1'b0;
        bus.imem_valid = 1'b1;
        bus.imem_data  = 32'h0040_0213;
        step();
        bus.imem_valid = 1'b0;
        #1;
        chk("t2_full", 32'(count), 4);
        bus.instr_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk("t2_order", bus.instr_pc, 32'(k));
            step();
        end
        bus.instr_ready = 1'b0;

        // Flush during WAIT, late return discarded.
        pc = 32'd7;
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        bus.imem_ready = 1'b1;
        step();
        bus.imem_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        step();
        bus.imem_valid = 1'b1;
        bus.imem_data  = 32'hDEADBEEF;
        step();
        bus.imem_valid = 1'b0;
        #1;
        chk("t3_count", 32'(count), 0);
        chk("t3_busy", 32'(busy), 0);
        fetch(32'd8, 32'h0020_8033);
        #1;
        chk("t3_pc", bus.instr_pc, 8);
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;

        // Flush with return in the same cycle, then flush in REQ.
        pc = 32'd9;
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        bus.imem_ready = 1'b1;
        step();
        bus.imem_ready = 1'b0;
        flush = 1'b1;
        bus.imem_valid = 1'b1;
        bus.imem_data  = 32'hBAD0BAD0;
        step();
        flush = 1'b0;
        bus.imem_valid = 1'b0;
        #1;
        chk("t4_count", 32'(count), 0);
        chk("t4_idle", 32'(busy), 0);
        pc = 32'd10;
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        flush = 1'b1;
        bus.imem_ready = 1'b1;
        step();
        flush = 1'b0;
        bus.imem_ready = 1'b0;
        #1;
        chk("t4_req_drop", 32'(bus.imem_req), 0);
        step();
        #1;
        chk("t4_req_next", 32'(bus.imem_req), 0);

        // Slow memory acceptance and bne pre-decode.
        pc = 32'd5;
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        repeat (5) begin
            #1;
            chk("t5_req", 32'(bus.imem_req), 1);
            chk("t5_addr", bus.imem_addr, 5);
            step();
        end
        bus.imem_ready = 1'b1;
        step();
        bus.imem_ready = 1'b0;
        bus.imem_valid = 1'b1;
        bus.imem_data  = 32'h0020_9463;
        step();
        bus.imem_valid = 1'b0;
        fetch(32'd6, 32'h00B5_0533);
        #1;
        chk("t5_pc0", bus.instr_pc, 5);
        chk("t5_op", 32'(bus.operatorType), 32'h63);
        chk("t5_f3", 32'(bus.operatorSubType), 1);
        bus.instr_ready = 1'b1;
        step();
        #1;
        chk("t5_pc1", bus.instr_pc, 6);
        step();
        bus.instr_ready = 1'b0;

        // Async reset mid-WAIT with two entries queued.
        fetch(32'd11, 32'h0000_0093);
        fetch(32'd12, 32'h0000_0113);
        pc = 32'd20;
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        bus.imem_ready = 1'b1;
        step();
        bus.imem_ready = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_valid", 32'(bus.instr_valid), 0);
        chk("t6_count", 32'(count), 0);
        chk("t6_req", 32'(bus.imem_req), 0);
        chk("t6_pc", bus.instr_pc, 0);
        chk("t6_word", bus.instr_word, 0);
        chk("t6_addr", bus.imem_addr, 0);
        chk("t6_busy", 32'(busy), 0);
        step();
        rst_n = 1'b1;
        bus.imem_valid = 1'b1;
        bus.imem_data  = 32'hCAFEF00D;
        step();
        bus.imem_valid = 1'b0;
        #1;
        chk("t6_stale", 32'(count), 0);

        // Random traffic.
        prev_phase = phase;
        lat = 0;
        directed = 1'b0;
        repeat (4000) step();
        rst_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
